aesl_deadlock_report_arbiter: RTL

//   Downstream consumer of the per-process deadlock detect units in the cosim deadlock detector.

---
 rtl/aesl_deadlock_report_arbiter_pkg.sv | 31 +++
 rtl/aesl_deadlock_report_arbiter_if.sv | 31 +++
 rtl/aesl_deadlock_report_arbiter_rr_pick.sv | 34 +++
 rtl/aesl_deadlock_report_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_report_arbiter_pkg.sv
// Shared definitions for the cosim deadlock report arbiter.
// Contents: FSM state encodings, maximum supported process count,
//           index-width, one-hot and round-robin pointer helpers.
package aesl_dl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_CONFIRM = 3'd2;
  localparam logic [2:0] ST_CLEAR   = 3'd3;
  localparam logic [2:0] ST_REPORT  = 3'd4;

  // Upper bound on PROC_NUM supported by the one-hot helper
  localparam int unsigned MAX_PROC = 64;

  // Width of an index into n processes; never narrower than one bit
  function automatic int unsigned dl_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot vector with bit idx set; callers truncate to their width
  function automatic logic [MAX_PROC-1:0] dl_onehot(input int unsigned idx);
    return MAX_PROC'(1) << idx;
  endfunction

  // Round-robin successor of sel among n processes
  function automatic int unsigned dl_next_ptr(input int unsigned sel, input int unsigned n);
    return (sel + 1 >= n) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/aesl_deadlock_report_arbiter_if.sv
// Bundle between the deadlock detect units and the report arbiter.
// Signals:
//   dl_in_vec     per-process "deadlock suspected" flags (detect units -> arbiter)
//   dl_detect_out global deadlock confirmed, sticky           (arbiter -> out)
//   origin        one-hot selected origin process            (arbiter -> units)
//   token_clear   one-cycle pulse to drop circulating tokens (arbiter -> units)
// Modports: master = arbiter side, slave = detect unit side.
interface aesl_deadlock_report_arbiter_if #(
  parameter int unsigned PROC_NUM = 2
);

  logic [PROC_NUM-1:0] dl_in_vec;
  logic                dl_detect_out;
  logic [PROC_NUM-1:0] origin;
  logic                token_clear;

  modport master (
    input  dl_in_vec,
    output dl_detect_out,
    output origin,
    output token_clear
  );

  modport slave (
    output dl_in_vec,
    input  dl_detect_out,
    input  origin,
    input  token_clear
  );

endinterface

// File: rtl/aesl_deadlock_report_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        in   PROC_NUM  request flags
//   ptr        in   IW        highest-priority index this round
//   grant_idx  out  IW        first set request at or after ptr, wrapping
//   grant_vld  out  1         any request set
module aesl_dl_rr_pick
  import aesl_dl_pkg::*;
#(
  parameter  int unsigned PROC_NUM = 2,
  localparam int unsigned IW       = dl_idx_w(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_vld
);

  // Scan from ptr upward with wrap; the first hit wins
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < int'(PROC_NUM); i++) begin
      int j;
      j = int'(32'(ptr)) + i;
      if (j >= int'(PROC_NUM)) j = j - int'(PROC_NUM);
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/aesl_deadlock_report_arbiter.sv
// Deadlock report arbiter for the cosim deadlock detector (simulation only).
// Picks one suspected origin process round-robin, lets the detect units
// circulate a token, confirms that the origin's flag stays high for
// CONFIRM_CYCLES cycles, and then raises a sticky dl_detect_out. A candidate
// that does not confirm within TOKEN_TIMEOUT cycles is dropped with a
// token_clear pulse and the round-robin pointer moves past it.
// Ports:
//   clock   in   1     rising-edge clock
//   reset   in   1     asynchronous active-low reset
//   dl_if   master     dl_in_vec in; dl_detect_out, origin, token_clear out
module aesl_deadlock_report_arbiter
  import aesl_dl_pkg::*;
#(
  parameter  int unsigned PROC_NUM       = 2,
  parameter  int unsigned CONFIRM_CYCLES = 4,
  parameter  int unsigned TOKEN_TIMEOUT  = 1024,
  parameter  int unsigned FINISH_DELAY   = 16,
  localparam int unsigned IW             = dl_idx_w(PROC_NUM),
  localparam int unsigned CW             = $clog2(TOKEN_TIMEOUT + 1),
  localparam int unsigned FW             = (FINISH_DELAY > 0) ? $clog2(FINISH_DELAY + 1) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  aesl_deadlock_report_arbiter_if.master dl_if
);

  logic [2:0]          state_q,       state_d;
  logic [IW-1:0]       sel_q,         sel_d;
  logic [IW-1:0]       rr_ptr_q,      rr_ptr_d;
  logic [CW-1:0]       conf_q,        conf_d;
  logic [CW-1:0]       to_q,          to_d;
  logic [FW-1:0]       fin_q,         fin_d;
  logic [PROC_NUM-1:0] origin_q,      origin_d;
  logic                dl_detect_q,   dl_detect_d;
  logic                token_clear_q, token_clear_d;

  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic                sel_flag_c;

  aesl_dl_rr_pick #(
    .PROC_NUM (PROC_NUM)
  ) u_rr_pick (
    .req       (dl_if.dl_in_vec),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // origin is one-hot of sel while a candidate is held, so masking picks dl_in_vec[sel]
  assign sel_flag_c = |(dl_if.dl_in_vec & origin_q);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    conf_d        = conf_q;
    to_d          = to_q;
    fin_d         = fin_q;
    origin_d      = origin_q;
    dl_detect_d   = dl_detect_q;
    token_clear_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        origin_d = '0;
        if (grant_vld) begin
          sel_d    = grant_idx;
          origin_d = PROC_NUM'(dl_onehot(32'(grant_idx)));
          state_d  = ST_ARM;
        end
      end

      ST_ARM: begin
        conf_d  = '0;
        to_d    = '0;
        state_d = ST_CONFIRM;
      end

      ST_CONFIRM: begin
        if (to_q != {CW{1'b1}}) to_d = to_q + CW'(1);
        if (sel_flag_c) begin
          if (conf_q != {CW{1'b1}}) conf_d = conf_q + CW'(1);
        end else begin
          conf_d = '0;
        end
        // Confirmation wins over a timeout landing on the same cycle
        if (sel_flag_c && (conf_q == CW'(CONFIRM_CYCLES - 1))) begin
          state_d     = ST_REPORT;
          dl_detect_d = 1'b1;
          fin_d       = '0;
        end else if (to_q == CW'(TOKEN_TIMEOUT - 1)) begin
          state_d       = ST_CLEAR;
          token_clear_d = 1'b1;
          origin_d      = '0;
        end
      end

      ST_CLEAR: begin
        origin_d = '0;
        rr_ptr_d = IW'(dl_next_ptr(32'(sel_q), PROC_NUM));
        state_d  = ST_IDLE;
      end

      ST_REPORT: begin
        dl_detect_d = 1'b1;
        if (fin_q != {FW{1'b1}}) fin_d = fin_q + FW'(1);
      end

      default: begin
        state_d  = ST_IDLE;
        origin_d = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      conf_q        <= '0;
      to_q          <= '0;
      fin_q         <= '0;
      origin_q      <= '0;
      dl_detect_q   <= 1'b0;
      token_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      conf_q        <= conf_d;
      to_q          <= to_d;
      fin_q         <= fin_d;
      origin_q      <= origin_d;
      dl_detect_q   <= dl_detect_d;
      token_clear_q <= token_clear_d;
    end
  end

  // Report once on entry and optionally end the simulation afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      if ((state_q == ST_CONFIRM) && (state_d == ST_REPORT)) begin
        $display("aesl_deadlock_report_arbiter: deadlock confirmed, origin process %0d at time %0t",
                 sel_q, $time);
      end
      if ((FINISH_DELAY != 0) && (state_q == ST_REPORT) && (fin_q == FW'(FINISH_DELAY - 1))) begin
        $finish;
      end
    end
  end

  assign dl_if.origin        = origin_q;
  assign dl_if.dl_detect_out = dl_detect_q;
  assign dl_if.token_clear   = token_clear_q;

endmodule
